// File: rtl/memory_loader_pkg.sv
// Shared types and constants for the 10-word x 35-bit memory loader.
package memory_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } loader_state_e;

    localparam int LOADER_DATA_W = 35;
    localparam int LOADER_ADDR_W = 4;
    localparam int LOADER_BYTES  = 5;

endpackage

// File: rtl/memory_loader_10w_if.sv
// Byte-stream input and memory write-port bundle for the memory loader.
interface memory_loader_10w_if;
    import memory_loader_pkg::*;

    logic                     in_valid;
    logic [7:0]               in_byte;
    logic                     in_ready;
    logic                     WR;
    logic [LOADER_ADDR_W-1:0] wr_address_word;
    logic [LOADER_DATA_W-1:0] wr_data_word;

    modport master (
        output in_valid, in_byte,
        input  in_ready, WR, wr_address_word, wr_data_word
    );

    modport slave (
        input  in_valid, in_byte,
        output in_ready, WR, wr_address_word, wr_data_word
    );

endinterface

// File: rtl/memory_loader_packer.sv
// Byte slot register that assembles little-endian bytes into one stored word.
// MEMORY_LOADER_RANGE_CHECK_EN enables the sign-extension check on the discarded top bits.
module memory_loader_packer
    import memory_loader_pkg::*;
#(
    parameter int DATA_W = LOADER_DATA_W,
    parameter int BYTES  = LOADER_BYTES
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [2:0]        sel,
    input  logic [7:0]        din,
    output logic [DATA_W-1:0] word_next,
    output logic              ext_bad
);

    logic [7:0] slot_q [BYTES];
    logic [7:0] merged [BYTES];

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < BYTES; k++) slot_q[k] <= '0;
        end else if (clear) begin
            for (int k = 0; k < BYTES; k++) slot_q[k] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < BYTES; k++)
                if (sel == 3'(k)) slot_q[k] <= din;
        end
    end

    // The incoming byte is merged in so the word is complete on the cycle its last byte lands.
    always_comb begin
        for (int k = 0; k < BYTES; k++)
            merged[k] = (wr_en && sel == 3'(k)) ? din : slot_q[k];
    end

    always_comb begin
        word_next = '0;
        for (int b = 0; b < DATA_W; b++)
            word_next[b] = merged[b / 8][b % 8];
    end

`ifdef MEMORY_LOADER_RANGE_CHECK_EN
    always_comb begin
        ext_bad = 1'b0;
        for (int b = DATA_W; b < 8 * BYTES; b++)
            if (merged[b / 8][b % 8] != merged[(DATA_W - 1) / 8][(DATA_W - 1) % 8])
                ext_bad = 1'b1;
    end
`else
    assign ext_bad = 1'b0;
`endif

endmodule

// File: rtl/memory_loader_10w.sv
// Fill stage: packs a byte stream into 35-bit words and writes addresses 0..WORDS-1.
// err is only ever set when MEMORY_LOADER_RANGE_CHECK_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start, in_ready low
// COLLECT | accepting bytes of the current word
// WRITE   | single-cycle WR strobe for the packed word
// DONE    | single-cycle done pulse, then IDLE
module memory_loader_10w
    import memory_loader_pkg::*;
#(
    parameter int WORDS  = 10,
    parameter int DATA_W = LOADER_DATA_W
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic                start,
    memory_loader_10w_if.slave  bus,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int BYTES = (DATA_W + 7) / 8;

    loader_state_e            state_q, state_d;
    logic [2:0]               byte_cnt_q;
    logic [LOADER_ADDR_W-1:0] addr_q, wr_addr_q;
    logic [DATA_W-1:0]        wr_data_q, word_next;
    logic                     err_q, ext_bad;
    logic                     start_load, accept, last_byte;

    assign start_load = (state_q == IDLE) && start;
    assign accept     = (state_q == COLLECT) && bus.in_valid;
    assign last_byte  = accept && (byte_cnt_q == 3'(BYTES - 1));

    memory_loader_packer #(.DATA_W(DATA_W), .BYTES(BYTES)) u_packer (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .clear     (start_load),
        .wr_en     (accept),
        .sel       (byte_cnt_q),
        .din       (bus.in_byte),
        .word_next (word_next),
        .ext_bad   (ext_bad)
    );

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = COLLECT;
            COLLECT: if (last_byte) state_d = WRITE;
            WRITE:   state_d = (addr_q == LOADER_ADDR_W'(WORDS - 1)) ? DONE : COLLECT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write address/data are captured with the last byte so they hold until the next write.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            byte_cnt_q <= '0;
            addr_q     <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            if (start_load) begin
                byte_cnt_q <= '0;
                addr_q     <= '0;
                err_q      <= 1'b0;
            end
            if (accept)
                byte_cnt_q <= last_byte ? 3'd0 : byte_cnt_q + 3'd1;
            if (last_byte) begin
                wr_addr_q <= addr_q;
                wr_data_q <= word_next;
                if (ext_bad) err_q <= 1'b1;
            end
            if (state_q == WRITE && addr_q != LOADER_ADDR_W'(WORDS - 1))
                addr_q <= addr_q + 1'b1;
        end
    end

    assign bus.in_ready        = (state_q == COLLECT);
    assign bus.WR              = (state_q == WRITE);
    assign bus.wr_address_word = wr_addr_q;
    assign bus.wr_data_word    = wr_data_q;
    assign busy                = (state_q != IDLE);
    assign done                = (state_q == DONE);
    assign err                 = err_q;

endmodule

// File: tb/tb_memory_loader_10w.sv
// Directed-plus-random bench for memory_loader_10w against a byte-list reference model.
module tb_memory_loader_10w;
    import memory_loader_pkg::*;

    localparam int WORDS = 10;
    localparam int NB    = WORDS * LOADER_BYTES;

    logic CLOCK_50 = 1'b0;
    logic RESET    = 1'b1;
    logic start    = 1'b0;
    logic busy, done, err;

    memory_loader_10w_if bus ();

    memory_loader_10w #(.WORDS(WORDS)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    logic [7:0]  stim[$];
    logic [3:0]  log_addr[$];
    logic [34:0] log_data[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (bus.WR === 1'b1) begin
            log_addr.push_back(bus.wr_address_word);
            log_data.push_back(bus.wr_data_word);
            check("in_ready_during_write", 64'(bus.in_ready), 64'd0);
        end
    end

    function automatic logic [39:0] word40(input int w);
        logic [39:0] v;
        for (int k = 0; k < LOADER_BYTES; k++) v[8*k +: 8] = stim[LOADER_BYTES*w + k];
        return v;
    endfunction

    function automatic bit any_range_bad();
        logic [39:0] v;
        bit bad = 0;
        for (int w = 0; w < WORDS; w++) begin
            v = word40(w);
            if (v[39:35] != {5{v[34]}}) bad = 1;
        end
        return bad;
    endfunction

    task automatic gen_random();
        stim.delete();
        repeat (NB) stim.push_back(8'($urandom_range(0, 255)));
    endtask

    // Top byte of every word made a legal sign extension (FC or 03).
    task automatic sanitize_top();
        for (int w = 0; w < WORDS; w++)
            stim[LOADER_BYTES*w + 4] = ($urandom_range(0, 1) == 1) ? 8'hFC : 8'h03;
    endtask

    task automatic do_start();
        @(negedge CLOCK_50);
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("err_cleared_by_start", 64'(err), 64'd0);
    endtask

    task automatic feed(input int gap, input bit spam, input int stop_at,
                        output int cycles, output int consumed);
        int  idx = 0;
        bit  seen = 0;
        bit  acc;
        cycles = 0;
        while (!seen && cycles < 3000 && idx != stop_at) begin
            if (done === 1'b1) begin
                seen = 1;
                start = 1'b0;
                check("busy_with_done", 64'(busy), 64'd1);
            end else begin
                if (idx < NB) begin
                    bus.in_valid = ($urandom_range(0, 99) >= gap);
                    bus.in_byte  = bus.in_valid ? stim[idx] : 8'($urandom_range(0, 255));
                end else begin
                    bus.in_valid = 1'b0;
                end
                if (spam) start = ($urandom_range(0, 1) == 1);
                acc = bus.in_valid && bus.in_ready;
                @(posedge CLOCK_50);
                cycles++;
                if (acc) idx++;
                @(negedge CLOCK_50);
            end
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
        consumed     = idx;
        if (stop_at > NB) check("done_within_budget", 64'(seen), 64'd1);
    endtask

    task automatic after_done();
        logic [39:0] last;
        last = word40(WORDS - 1);
        @(negedge CLOCK_50);
        check("busy_low_after_done", 64'(busy), 64'd0);
        check("done_single_cycle", 64'(done), 64'd0);
        check("in_ready_idle", 64'(bus.in_ready), 64'd0);
        check("addr_held", 64'(bus.wr_address_word), 64'(WORDS - 1));
        check("data_held", 64'(bus.wr_data_word), 64'(last[34:0]));
    endtask

    task automatic check_load(input string tag);
        logic [39:0] v;
        bit exp_err;
        check($sformatf("%s_write_count", tag), 64'(log_addr.size()), 64'(WORDS));
        for (int w = 0; w < WORDS && w < log_addr.size(); w++) begin
            v = word40(w);
            check($sformatf("%s_addr%0d", tag, w), 64'(log_addr[w]), 64'(w));
            check($sformatf("%s_data%0d", tag, w), 64'(log_data[w]), 64'(v[34:0]));
        end
`ifdef MEMORY_LOADER_RANGE_CHECK_EN
        exp_err = any_range_bad();
`else
        exp_err = 1'b0;
`endif
        check($sformatf("%s_err", tag), 64'(err), 64'(exp_err));
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        int cyc, used;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;

        #35;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_wr", 64'(bus.WR), 64'd0);
        check("rst_addr", 64'(bus.wr_address_word), 64'd0);
        check("rst_data", 64'(bus.wr_data_word), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(negedge CLOCK_50);
        RESET = 1'b0;

        // Sequential bytes 0x00..0x31, no gaps: exact cycle count.
        stim.delete();
        for (int i = 0; i < NB; i++) stim.push_back(8'(i));
        do_start();
        feed(0, 0, NB + 1, cyc, used);
        check("min_load_cycles", 64'(cyc), 64'(1 + WORDS * (LOADER_BYTES + 1) + 1 - 2));
        check("seq_bytes_used", 64'(used), 64'(NB));
        check("word0_const", (log_data.size() > 0) ? 64'(log_data[0]) : 64'hdead, 64'h4_0302_0100);
        after_done();
        check_load("seq");

        // Random bytes with random in_valid gaps.
        gen_random();
        do_start();
        feed(40, 0, NB + 1, cyc, used);
        check("gap_load_not_faster", 64'(cyc >= 60), 64'd1);
        after_done();
        check_load("gap");

        // start pulsed repeatedly while busy.
        gen_random();
        do_start();
        feed(20, 1, NB + 1, cyc, used);
        after_done();
        check_load("spam");
        repeat (10) @(negedge CLOCK_50);
        check("no_restart_writes", 64'(log_addr.size()), 64'd0);
        check("no_restart_busy", 64'(busy), 64'd0);

        // Reset after 3 bytes of word 4.
        gen_random();
        do_start();
        feed(0, 0, 4 * LOADER_BYTES + 3, cyc, used);
        check("pre_reset_writes", 64'(log_addr.size()), 64'd4);
        RESET = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("mid_rst_wr", 64'(bus.WR), 64'd0);
        check("mid_rst_addr", 64'(bus.wr_address_word), 64'd0);
        check("mid_rst_data", 64'(bus.wr_data_word), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        log_addr.delete();
        log_data.delete();
        @(negedge CLOCK_50);
        RESET = 1'b0;
        gen_random();
        do_start();
        feed(10, 0, NB + 1, cyc, used);
        after_done();
        check_load("post_reset");

        // Word 3 = 00 00 00 00 0F: bad sign extension (only flagged with range check).
        gen_random();
        sanitize_top();
        for (int k = 0; k < 4; k++) stim[3*LOADER_BYTES + k] = 8'h00;
        stim[3*LOADER_BYTES + 4] = 8'h0F;
        do_start();
        feed(0, 0, NB + 1, cyc, used);
        after_done();
        check_load("bad_ext");

        // Word 0 = 00 00 00 00 FC and all words legal: err stays 0.
        gen_random();
        sanitize_top();
        for (int k = 0; k < 4; k++) stim[k] = 8'h00;
        stim[4] = 8'hFC;
        do_start();
        feed(0, 0, NB + 1, cyc, used);
        after_done();
        check("good_ext_err", 64'(err), 64'd0);
        check_load("good_ext");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
